// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding and default parameters for the PLL lock sequencer
package pll_seq_pkg;

    typedef enum logic [1:0] {
        PLL_RESET = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } pll_state_e;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 50000;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_CNT_W         = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer with asynchronous active-low reset
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // two back-to-back flops; only q is safe to use in the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: drives PLL reset, waits for stable lock, releases system reset
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             ready,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] relock_count,
    output logic [CNT_W-1:0] timeout_count
);

    localparam int TMAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int TW   = $clog2(TMAX);

    pll_state_e      state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            locked_s;
    logic            to_inc, rl_inc;

    sync_2ff u_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    // next state, event pulses and shared timer; lock wins over a same-cycle timeout
    always_comb begin
        state_d = state_q;
        to_inc  = 1'b0;
        rl_inc  = 1'b0;
        case (state_q)
            PLL_RESET: state_d = (timer_q == TW'(RST_CYCLES - 1)) ? WAIT_LOCK : PLL_RESET;
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
                    state_d = PLL_RESET;
                    to_inc  = 1'b1;
                end
            end
            STABLE: state_d = !locked_s ? WAIT_LOCK :
                              (timer_q == TW'(STABLE_CYCLES - 1)) ? RUN : STABLE;
            RUN: begin
                if (!locked_s) begin
                    state_d = PLL_RESET;
                    rl_inc  = 1'b1;
                end
            end
            default: state_d = PLL_RESET;
        endcase
        timer_d = (state_d != state_q || state_q == RUN) ? '0 : timer_q + TW'(1);
    end

    // state, timer, registered outputs and saturating debug counters
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= PLL_RESET;
            timer_q       <= '0;
            pll_rst       <= 1'b1;
            sys_rst_n     <= 1'b0;
            ready         <= 1'b0;
            relock_count  <= '0;
            timeout_count <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            pll_rst       <= (state_d == PLL_RESET);
            sys_rst_n     <= (state_d == RUN);
            ready         <= (state_d == RUN);
            relock_count  <= relock_count + CNT_W'(rl_inc && relock_count != '1);
            timeout_count <= timeout_count + CNT_W'(to_inc && timeout_count != '1);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed checks of reset pulse, timeouts, lock, glitch, relock and async reset
module tb_pll_lock_sequencer;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic [1:0] state;
    logic [1:0] relock_count;
    logic [1:0] timeout_count;
    int         total = 0;
    int         bad   = 0;
    int         n;

    pll_lock_sequencer #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .CNT_W         (2)
    ) dut (
        .refclk        (refclk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .pll_rst       (pll_rst),
        .sys_rst_n     (sys_rst_n),
        .ready         (ready),
        .state         (state),
        .relock_count  (relock_count),
        .timeout_count (timeout_count)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge refclk);
    endtask

    initial begin
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        cyc(2);
        chk("rst_state", state, 0);
        chk("rst_pll_rst", pll_rst, 1);
        chk("rst_sys_rst_n", sys_rst_n, 0);
        chk("rst_ready", ready, 0);
        chk("rst_relock", relock_count, 0);
        chk("rst_timeout", timeout_count, 0);
        rst_n = 1'b1;
        n = 0;
        while (pll_rst && n < 50) begin
            n++;
            cyc(1);
        end
        chk("first_pulse_len", n, 4);
        chk("wait_after_pulse", state, 1);
        for (int k = 1; k <= 5; k++) begin
            cyc(19);
            chk("wl_last_cycle", pll_rst, 0);
            cyc(1);
            chk("to_pll_rst", pll_rst, 1);
            chk("to_count", timeout_count, (k > 3) ? 3 : k);
            cyc(4);
            chk("to_back_wait", state, 1);
        end
        cyc(5);
        pll_locked = 1'b1;
        cyc(2);
        chk("sync_delay", state, 1);
        cyc(1);
        chk("enter_stable", state, 2);
        cyc(4);
        pll_locked = 1'b0;
        cyc(1);
        pll_locked = 1'b1;
        cyc(1);
        chk("glitch_t6_stable", state, 2);
        cyc(1);
        chk("glitch_to_wait", state, 1);
        cyc(1);
        chk("glitch_restable", state, 2);
        cyc(7);
        chk("stable_not_ready", ready, 0);
        cyc(1);
        chk("run_ready", ready, 1);
        chk("run_sys_rst_n", sys_rst_n, 1);
        chk("run_state", state, 3);
        chk("run_pll_rst", pll_rst, 0);
        cyc(2);
        pll_locked = 1'b0;
        cyc(2);
        chk("loss_still_run", sys_rst_n, 1);
        cyc(1);
        chk("loss_sys_rst_n", sys_rst_n, 0);
        chk("loss_pll_rst", pll_rst, 1);
        chk("loss_relock", relock_count, 1);
        chk("loss_state", state, 0);
        chk("loss_timeout_kept", timeout_count, 3);
        cyc(4);
        chk("relock_wait", state, 1);
        pll_locked = 1'b1;
        cyc(3);
        chk("relock_stable", state, 2);
        cyc(8);
        chk("relock_run", ready, 1);
        pll_locked = 1'b0;
        cyc(3);
        chk("loss2_relock", relock_count, 2);
        cyc(4);
        pll_locked = 1'b1;
        cyc(3);
        chk("mid_stable", state, 2);
        cyc(3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_state", state, 0);
        chk("async_pll_rst", pll_rst, 1);
        chk("async_sys_rst_n", sys_rst_n, 0);
        chk("async_relock", relock_count, 0);
        chk("async_timeout", timeout_count, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
